// File: rtl/adc_pkg.sv
// Shared ADC definitions: sample word width/type and accumulator sizing.
package adc_pkg;

  localparam int SAMPLE_W = 16;

  typedef logic [SAMPLE_W-1:0] sample_t;

  // Sum of 2^log2_n full-scale samples needs log2_n extra bits, never more.
  function automatic int sum_width(input int log2_n);
    return SAMPLE_W + log2_n;
  endfunction

endpackage

// File: rtl/adc_moving_average_if.sv
// Sample/average bus between the ADC front end (master) and the averager (slave).
interface adc_moving_average_if #(
  parameter int LOG2_N = 3
) ();
  import adc_pkg::*;

  sample_t           sample_in;
  logic              sample_rdy;
  logic              clear;
  sample_t           avg_out;
  logic              avg_valid;
  logic              window_full;
  logic [LOG2_N:0]   fill_count;

  modport master (
    output sample_in, sample_rdy, clear,
    input  avg_out, avg_valid, window_full, fill_count
  );

  modport slave (
    input  sample_in, sample_rdy, clear,
    output avg_out, avg_valid, window_full, fill_count
  );

endinterface

// File: rtl/sample_ring_buffer.sv
// Read-first circular sample store; returns the entry being overwritten.
module sample_ring_buffer #(
  parameter int LOG2_N   = 3,
  parameter int SAMPLE_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush_i,
  input  logic                we_i,
  input  logic [SAMPLE_W-1:0] wdata_i,
  output logic [SAMPLE_W-1:0] oldest_o,
  output logic                wrap_o
);

  localparam int N = 1 << LOG2_N;

  logic [SAMPLE_W-1:0] mem_q [N];
  logic [SAMPLE_W-1:0] oldest_q;
  logic [LOG2_N-1:0]   wr_ptr_q;
  logic [LOG2_N-1:0]   wr_ptr_d;
  logic                wrap_q;

  // Pointer width equals LOG2_N, so the increment wraps N-1 -> 0 by itself.
  assign wr_ptr_d = wr_ptr_q + LOG2_N'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      wrap_q   <= 1'b0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      wrap_q   <= 1'b0;
    end else begin
      wrap_q <= we_i && (wr_ptr_q == LOG2_N'(N - 1));
      if (we_i) begin
        wr_ptr_q <= wr_ptr_d;
      end
    end
  end

  // Storage is never cleared; fill tracking upstream decides what is meaningful.
  always_ff @(posedge clk) begin
    if (we_i) begin
      oldest_q         <= mem_q[wr_ptr_q];
      mem_q[wr_ptr_q]  <= wdata_i;
    end
  end

  assign oldest_o = oldest_q;
  assign wrap_o   = wrap_q;

endmodule

// File: rtl/adc_moving_average.sv
// Boxcar moving average over the last 2^LOG2_N ADC samples, one strobe per result.
module adc_moving_average #(
  parameter int LOG2_N   = 3,
  parameter int SAMPLE_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  adc_moving_average_if.slave   avg_if
);
  import adc_pkg::*;

  localparam int              N     = 1 << LOG2_N;
  localparam int              SUM_W = sum_width(LOG2_N);
  localparam logic [LOG2_N:0] N_CNT = (LOG2_N + 1)'(N);

  function automatic logic [SAMPLE_W-1:0] trunc_avg(input logic [SUM_W-1:0] s);
    return s[SUM_W-1 -: SAMPLE_W];
  endfunction

  logic                rdy_q;
  logic                accept;
  logic                vld_p1_q;
  logic [SAMPLE_W-1:0] sample_p1_q;
  logic [SAMPLE_W-1:0] oldest_p1;
  logic                ring_wrap_unused;

  logic [SUM_W-1:0]    sum_q, sum_d;
  logic [LOG2_N:0]     fill_q, fill_d;
  logic                full_q, full_d;
  logic [SAMPLE_W-1:0] avg_q, avg_d;
  logic                avg_vld_q;

  // A held-high ready level yields one sample; a clear on the same edge drops it.
  assign accept = avg_if.sample_rdy && !rdy_q && !avg_if.clear;

  // ---- stage 1: capture new sample, ring buffer swaps it for the oldest ----
  sample_ring_buffer #(
    .LOG2_N   (LOG2_N),
    .SAMPLE_W (SAMPLE_W)
  ) u_ring (
    .clk      (clk),
    .reset    (reset),
    .flush_i  (avg_if.clear),
    .we_i     (accept),
    .wdata_i  (avg_if.sample_in),
    .oldest_o (oldest_p1),
    .wrap_o   (ring_wrap_unused)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      sample_p1_q <= avg_if.sample_in;
    end
  end

  // ---- stage 2: running-sum update and output ----
  assign sum_d  = sum_q + SUM_W'(sample_p1_q) - (full_q ? SUM_W'(oldest_p1) : '0);
  assign fill_d = (fill_q == N_CNT) ? N_CNT : fill_q + (LOG2_N + 1)'(1);
  assign full_d = (fill_d == N_CNT);
  assign avg_d  = trunc_avg(sum_d);

  always_ff @(posedge clk) begin
    if (!reset) begin
      rdy_q     <= 1'b0;
      vld_p1_q  <= 1'b0;
      sum_q     <= '0;
      fill_q    <= '0;
      full_q    <= 1'b0;
      avg_q     <= '0;
      avg_vld_q <= 1'b0;
    end else begin
      rdy_q     <= avg_if.sample_rdy;
      avg_vld_q <= 1'b0;
      if (avg_if.clear) begin
        vld_p1_q <= 1'b0;
        sum_q    <= '0;
        fill_q   <= '0;
        full_q   <= 1'b0;
      end else begin
        vld_p1_q <= accept;
        if (vld_p1_q) begin
          sum_q  <= sum_d;
          fill_q <= fill_d;
          full_q <= full_d;
          if (full_d) begin
            avg_q     <= avg_d;
            avg_vld_q <= 1'b1;
          end
        end
      end
    end
  end

  assign avg_if.avg_out     = avg_q;
  assign avg_if.avg_valid   = avg_vld_q;
  assign avg_if.window_full = full_q;
  assign avg_if.fill_count  = fill_q;

endmodule

// File: tb/tb_adc_moving_average.sv
// Directed and randomized checks of adc_moving_average against a queue-based window model.
module tb_adc_moving_average;
  import adc_pkg::*;

  localparam int LOG2_N = 2;
  localparam int N      = 1 << LOG2_N;

  logic clk = 1'b0;
  logic reset;

  adc_moving_average_if #(.LOG2_N(LOG2_N)) bus ();

  adc_moving_average #(
    .LOG2_N   (LOG2_N),
    .SAMPLE_W (SAMPLE_W)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .avg_if (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference: the window is simply the last N accepted samples, applied one cycle after acceptance.
  int unsigned win[$];
  bit          pend;
  int unsigned pend_s;
  bit          prev_rdy;
  int unsigned m_avg;
  bit          m_vld;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  task automatic model_step();
    int unsigned s;
    if (!reset) begin
      win.delete();
      pend     = 1'b0;
      prev_rdy = 1'b0;
      m_avg    = 0;
      m_vld    = 1'b0;
    end else begin
      m_vld = 1'b0;
      if (bus.clear) begin
        win.delete();
        pend = 1'b0;
      end else begin
        if (pend) begin
          win.push_back(pend_s);
          if (win.size() > N) void'(win.pop_front());
          if (win.size() == N) begin
            s = 0;
            foreach (win[i]) s += win[i];
            m_avg = s / N;
            m_vld = 1'b1;
          end
        end
        pend   = bus.sample_rdy && !prev_rdy;
        pend_s = 32'(bus.sample_in);
      end
      prev_rdy = bus.sample_rdy;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("avg_out",     32'(bus.avg_out),     m_avg);
    chk("avg_valid",   32'(bus.avg_valid),   32'(m_vld));
    chk("fill_count",  32'(bus.fill_count),  unsigned'(win.size()));
    chk("window_full", 32'(bus.window_full), 32'(win.size() == N));
  endtask

  task automatic pulse(input int unsigned s);
    bus.sample_in  = 16'(s);
    bus.sample_rdy = 1'b1;
    cycle();
    bus.sample_rdy = 1'b0;
    cycle();
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    cycle();
    bus.clear = 1'b0;
  endtask

  initial begin
    reset          = 1'b0;
    bus.sample_in  = '0;
    bus.sample_rdy = 1'b0;
    bus.clear      = 1'b0;
    cycle();
    cycle();
    chk("rst_avg",   32'(bus.avg_out),     0);
    chk("rst_valid", 32'(bus.avg_valid),   0);
    chk("rst_fill",  32'(bus.fill_count),  0);
    chk("rst_full",  32'(bus.window_full), 0);
    reset = 1'b1;
    cycle();

    // Warm-up, then first result on the Nth sample
    pulse(100); pulse(200); pulse(300);
    chk("t1_nowarm", 32'(bus.avg_valid), 0);
    pulse(400);
    chk("t1_avg",   32'(bus.avg_out),     250);
    chk("t1_valid", 32'(bus.avg_valid),   1);
    chk("t1_fill",  32'(bus.fill_count),  4);
    chk("t1_full",  32'(bus.window_full), 1);
    cycle();
    chk("t1_strobe", 32'(bus.avg_valid), 0);

    // Sliding window
    pulse(800);
    chk("t2_avg425", 32'(bus.avg_out), 425);
    pulse(0);
    chk("t2_avg375", 32'(bus.avg_out), 375);

    // Full-scale samples
    repeat (4) pulse(16'hFFFF);
    chk("t3_ffff", 32'(bus.avg_out), 32'hFFFF);
    pulse(0);
    chk("t3_bfff", 32'(bus.avg_out), 32'hBFFF);

    // Held ready level counts once
    do_clear();
    bus.sample_in  = 16'd500;
    bus.sample_rdy = 1'b1;
    repeat (6) cycle();
    bus.sample_rdy = 1'b0;
    cycle();
    chk("t4_fill", 32'(bus.fill_count), 1);

    // Clear coincident with a sample edge
    do_clear();
    pulse(7); pulse(7); pulse(7);
    bus.sample_in  = 16'd7;
    bus.sample_rdy = 1'b1;
    bus.clear      = 1'b1;
    cycle();
    bus.sample_rdy = 1'b0;
    bus.clear      = 1'b0;
    cycle();
    chk("t5_fill",  32'(bus.fill_count), 0);
    chk("t5_valid", 32'(bus.avg_valid),  0);
    repeat (4) pulse(40);
    chk("t5_avg", 32'(bus.avg_out), 40);

    // Reset with a sample in flight
    pulse(10); pulse(20);
    bus.sample_in  = 16'd30;
    bus.sample_rdy = 1'b1;
    cycle();
    bus.sample_rdy = 1'b0;
    reset          = 1'b0;
    cycle();
    reset = 1'b1;
    chk("t6_avg",   32'(bus.avg_out),    0);
    chk("t6_valid", 32'(bus.avg_valid),  0);
    chk("t6_fill",  32'(bus.fill_count), 0);
    pulse(1); pulse(2); pulse(3);
    chk("t6_warm", 32'(bus.avg_valid), 0);
    pulse(6);
    chk("t6_avg3", 32'(bus.avg_out), 3);

    // Randomized traffic, including full-scale samples, clears and resets
    repeat (3000) begin
      bus.sample_rdy = 1'($urandom_range(0, 1));
      bus.sample_in  = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      bus.clear      = ($urandom_range(0, 63) == 0);
      reset          = ($urandom_range(0, 255) != 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adc_moving_average.md
Name: adc_moving_average

Overview:
- Sits directly downstream of the R2R ADC top level.
- Consumes its 16-bit raw sample word and its data-ready indication.
- Produces a boxcar moving average over the last 2^LOG2_N samples, with a one-cycle valid strobe per new averaged result.
- Smooths comparator/ladder noise before display or UART stages. Contains a sample ring buffer, a running-sum accumulator and a two-stage update pipeline.

Parameters:
- LOG2_N, 3, log2 of window length N (N = 2^LOG2_N); legal range 1..8.
- SAMPLE_W, 16, input sample width; must equal the ADC output word width.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- sample_in  input  SAMPLE_W  raw ADC sample; valid whenever sample_rdy rises
- sample_rdy  input  1  ADC data-ready; may be a 1-cycle pulse or a multi-cycle level
- clear  input  1  synchronous flush of window (e.g. on ADC mode change)
- avg_out  output  SAMPLE_W  current window average
- avg_valid  output  1  1-cycle strobe: avg_out updated
- window_full  output  1  high once N samples are held since last reset/clear
- fill_count  output  LOG2_N+1  number of samples in window, 0..N

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low. reset==0 at a clk edge forces:
  - avg_out=0, avg_valid=0, window_full=0, fill_count=0
  - running sum=0, write pointer=0, edge-detect register=0
  - pipeline stage-1 valid=0
  - Ring-buffer contents are not cleared.
- Sample acceptance:
  - A sample is accepted at edge t when sample_rdy==1 at t and was 0 at t-1 (registered rising-edge detect).
  - A level held high for many cycles yields exactly one sample.
  - sample_in is captured at edge t.
- Pipeline:
  - Stage 1 (edge t): capture new sample; read oldest = mem[wr_ptr]; write new sample to mem[wr_ptr]; wr_ptr increments modulo N.
  - Stage 2 (edge t+1):
    - sum <= sum + new - (window_full ? oldest : 0)
    - fill_count saturates at N; window_full <= (fill_count_next == N).
- Arithmetic:
  - Sum register width is SAMPLE_W+LOG2_N; it never overflows (N × 0xFFFF fits).
  - The read-before-write in stage 1 returns the old value at that address (read-first semantics).
- Output, at edge t+1:
  - While not full: avg_out holds its previous value and avg_valid stays 0 (warm-up, no output).
  - Once full after this update: avg_out <= sum_next >> LOG2_N (truncating, no rounding) and avg_valid=1 for exactly one cycle.
  - The first valid result occurs on the N-th accepted sample.
- Back-to-back: the ADC cannot produce rising edges closer than 2 cycles. If edges arrive on consecutive cycles, each is still processed, because stage 2 forwards stage-1 data with no stall. No sample loss at full rate of one edge per 2 cycles.
- clear==1 at an edge:
  - Same effect as reset on sum, wr_ptr, fill_count, window_full and stage-1 valid.
  - avg_out is retained; avg_valid is forced 0.
  - A sample edge coincident with clear is dropped.
  - A sample in stage 1 when clear asserts is discarded.
- Priority: reset > clear > sample.
- Wrap-around: wr_ptr wraps N-1 -> 0 silently. After wrap, the oldest read is always exactly the sample accepted N samples earlier.

Decomposition:
- Shared package adc_pkg:
  - localparam SAMPLE_W=16, shared with the ADC top level.
  - typedef logic [SAMPLE_W-1:0] sample_t.
  - Function to compute sum width from LOG2_N.
- One natural sub-module: sample_ring_buffer.
  - Parameterised depth 2^LOG2_N, width SAMPLE_W, single write/read port, read-first.
  - Internally owns wr_ptr; exposes oldest data and a wrap flag.

Test Plan:
1. LOG2_N=2; samples 100,200,300,400 as 1-cycle pulses -> avg_valid only after the 4th, avg_out=250, window_full=1, fill_count=4.
2. Continue from 1 with sample 800 -> sum=1700, avg_out=425 one cycle after acceptance. Then 0 -> avg_out=375.
3. Four samples of 0xFFFF -> avg_out=0xFFFF, no wrap; then 0x0000 -> avg_out=0xBFFF.
4. sample_rdy held high 6 cycles with sample_in=500 -> fill_count increments by exactly 1; no extra avg_valid.
5. After 3 samples, assert clear coincident with a 4th sample edge -> fill_count=0, sample dropped, avg_valid stays 0. The next 4 samples of 40 give avg_out=40.
6. reset=0 for one cycle mid-window with a sample in stage 1 -> all outputs 0 next cycle, no avg_valid. Warm-up restarts and needs N fresh samples.
